// File: rtl/input_vc_buffer.sv
// Router input port: one circular flit FIFO per virtual channel, per-VC IDLE/ACTIVE
// packet tracking, switch requests to the allocator, and one credit return per cycle.
module input_vc_buffer #(
  parameter int vc_Num    = 4,
  parameter int port_Num  = 5,
  parameter int buf_Depth = 4,
  parameter int flit_W    = 32,
  localparam int PW = $clog2(port_Num),
  localparam int VW = $clog2(vc_Num)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flit_valid_i,
  input  logic [flit_W-1:0]              flit_i,
  output logic [vc_Num-1:0]              request_o,
  output logic [vc_Num-1:0][PW-1:0]      out_port_o,
  input  logic [vc_Num-1:0]              grant_i,
  output logic                           flit_valid_o,
  output logic [flit_W-1:0]              flit_o,
  output logic [PW-1:0]                  flit_port_o,
  output logic                           credit_valid_o,
  output logic [VW-1:0]                  credit_vc_o,
  output logic                           overflow_o,
  output logic                           proto_err_o
);
  localparam int AW = $clog2(buf_Depth);
  localparam int CW = AW + 1;
  localparam int HB = flit_W - 1;
  localparam int TB = flit_W - 2;
  localparam int VB = flit_W - 3;
  localparam int DB = flit_W - 3 - VW;

  logic [flit_W-1:0] r_mem [vc_Num][buf_Depth];
  logic [AW-1:0]     r_rd_ptr [vc_Num];
  logic [AW-1:0]     r_wr_ptr [vc_Num];
  logic [CW-1:0]     r_cnt [vc_Num];
  logic              r_active [vc_Num];
  logic [PW-1:0]     r_port [vc_Num];

  logic [flit_W-1:0] w_front [vc_Num];
  logic [vc_Num-1:0] w_nonempty, w_full, w_req, w_bad_front;
  logic [vc_Num-1:0] w_wr_sel, w_wr_ok, w_pop, w_grant_pop, w_discard_pop, w_gvalid;
  logic [vc_Num-1:0][PW-1:0] w_out_port;
  logic [VW-1:0]     w_wr_vc, w_sel_vc;
  logic              w_any_grant, w_any_discard, w_grant_err;

  assign w_wr_vc = flit_i[VB -: VW];

  genvar gi;
  generate
    for (gi = 0; gi < vc_Num; gi++) begin : g_vc
      assign w_front[gi]     = r_mem[gi][r_rd_ptr[gi]];
      assign w_nonempty[gi]  = (r_cnt[gi] != '0);
      assign w_full[gi]      = (r_cnt[gi] == CW'(buf_Depth));
      assign w_req[gi]       = w_nonempty[gi] & (r_active[gi] | w_front[gi][HB]);
      // A body/tail flit at the front of an idle VC has lost its head: drop it.
      assign w_bad_front[gi] = w_nonempty[gi] & ~r_active[gi] & ~w_front[gi][HB];
      assign w_out_port[gi]  = r_active[gi] ? r_port[gi] : w_front[gi][DB -: PW];
      assign w_wr_sel[gi]    = flit_valid_i && (w_wr_vc == VW'(gi));
      assign w_wr_ok[gi]     = w_wr_sel[gi] & (~w_full[gi] | w_pop[gi]);
    end
  endgenerate

  assign request_o  = w_req;
  assign out_port_o = w_out_port;
  assign w_gvalid   = grant_i & w_req;
  assign w_pop      = w_grant_pop | w_discard_pop;
  assign w_grant_err = ($countones(grant_i) > 1) || (|(grant_i & ~w_req));

  // Forwarding wins the single credit slot; discards wait for a cycle without a grant.
  always_comb begin
    w_grant_pop   = '0;
    w_discard_pop = '0;
    w_sel_vc      = '0;
    w_any_grant   = 1'b0;
    w_any_discard = 1'b0;
    for (int v = 0; v < vc_Num; v++) begin
      if (w_gvalid[v] && !w_any_grant) begin
        w_grant_pop[v] = 1'b1;
        w_sel_vc       = VW'(v);
        w_any_grant    = 1'b1;
      end
    end
    if (!w_any_grant) begin
      for (int v = 0; v < vc_Num; v++) begin
        if (w_bad_front[v] && !w_any_discard) begin
          w_discard_pop[v] = 1'b1;
          w_sel_vc         = VW'(v);
          w_any_discard    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < vc_Num; v++) begin
      if (w_wr_ok[v]) r_mem[v][r_wr_ptr[v]] <= flit_i;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int v = 0; v < vc_Num; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_cnt[v]    <= '0;
        r_active[v] <= 1'b0;
        r_port[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < vc_Num; v++) begin
        if (w_wr_ok[v]) r_wr_ptr[v] <= r_wr_ptr[v] + 1'b1;
        if (w_pop[v])   r_rd_ptr[v] <= r_rd_ptr[v] + 1'b1;
        if (w_wr_ok[v] && !w_pop[v])      r_cnt[v] <= r_cnt[v] + 1'b1;
        else if (!w_wr_ok[v] && w_pop[v]) r_cnt[v] <= r_cnt[v] - 1'b1;
        if (w_grant_pop[v]) begin
          if (w_front[v][HB]) begin
            r_active[v] <= ~w_front[v][TB];
            r_port[v]   <= w_front[v][DB -: PW];
          end else if (w_front[v][TB]) begin
            r_active[v] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      flit_valid_o   <= 1'b0;
      flit_o         <= '0;
      flit_port_o    <= '0;
      credit_valid_o <= 1'b0;
      credit_vc_o    <= '0;
      overflow_o     <= 1'b0;
      proto_err_o    <= 1'b0;
    end else begin
      flit_valid_o   <= w_any_grant;
      credit_valid_o <= w_any_grant | w_any_discard;
      credit_vc_o    <= w_sel_vc;
      if (w_any_grant) begin
        flit_o      <= w_front[w_sel_vc];
        flit_port_o <= w_out_port[w_sel_vc];
      end
      overflow_o  <= overflow_o | (|(w_wr_sel & w_full & ~w_pop));
      proto_err_o <= proto_err_o | w_grant_err | w_any_discard;
    end
  end
endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench for input_vc_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based packet model.
module tb_input_vc_buffer;
  localparam int VC = 4, PN = 5, BD = 4, FW = 32;
  localparam int PW = $clog2(PN), VW = $clog2(VC);

  logic clk = 1'b0;
  logic rst_n;
  logic flit_valid_i;
  logic [FW-1:0] flit_i;
  logic [VC-1:0] request_o;
  logic [VC-1:0][PW-1:0] out_port_o;
  logic [VC-1:0] grant_i;
  logic flit_valid_o;
  logic [FW-1:0] flit_o;
  logic [PW-1:0] flit_port_o;
  logic credit_valid_o;
  logic [VW-1:0] credit_vc_o;
  logic overflow_o, proto_err_o;

  input_vc_buffer #(.vc_Num(VC), .port_Num(PN), .buf_Depth(BD), .flit_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .flit_valid_i(flit_valid_i), .flit_i(flit_i),
    .request_o(request_o), .out_port_o(out_port_o), .grant_i(grant_i),
    .flit_valid_o(flit_valid_o), .flit_o(flit_o), .flit_port_o(flit_port_o),
    .credit_valid_o(credit_valid_o), .credit_vc_o(credit_vc_o),
    .overflow_o(overflow_o), .proto_err_o(proto_err_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          fv;
    logic [FW-1:0] flit;
    logic [PW-1:0] port;
    logic [VW-1:0] cvc;
  } exp_t;

  exp_t          sb_q[$];
  logic [FW-1:0] mq [VC][$];
  bit            m_active [VC];
  logic [PW-1:0] m_port [VC];
  bit            m_ovf, m_perr;
  bit            in_rst = 1'b1;
  bit            in_pkt [VC];
  int            n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input bit h, input bit t, input int vc,
                                       input int dest, input logic [31:0] pl);
    logic [FW-1:0] f;
    f = FW'(pl);
    f[FW-1] = h;
    f[FW-2] = t;
    f[FW-3 -: VW] = VW'(vc);
    f[FW-3-VW -: PW] = PW'(dest);
    return f;
  endfunction

  function automatic logic [VC-1:0] model_req();
    logic [VC-1:0] r;
    r = '0;
    for (int i = 0; i < VC; i++)
      if (mq[i].size() > 0) r[i] = m_active[i] || mq[i][0][FW-1];
    return r;
  endfunction

  // Monitor: every output the DUT presents must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!in_rst && (flit_valid_o === 1'b1 || credit_valid_o === 1'b1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {flit_valid_o, credit_valid_o}, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("out: fv=%0b vc=%0d flit=%08h port=%0d", flit_valid_o, credit_vc_o, flit_o, flit_port_o);
        check("flit_valid", flit_valid_o, e.fv);
        check("credit_valid", credit_valid_o, 1);
        check("credit_vc", credit_vc_o, e.cvc);
        if (e.fv) begin
          check("flit_data", flit_o, e.flit);
          check("flit_port", flit_port_o, e.port);
        end
      end
    end
  end

  // One clock cycle: drive at the falling edge, check combinational outputs, advance the model.
  task automatic step(input bit v, input logic [FW-1:0] f, input logic [VC-1:0] g);
    logic [VC-1:0] req;
    logic [PW-1:0] op [VC];
    logic [FW-1:0] fr;
    int pv, dv, wv;
    flit_valid_i = v; flit_i = f; grant_i = g;
    #1;
    req = model_req();
    for (int i = 0; i < VC; i++)
      op[i] = m_active[i] ? m_port[i] : (mq[i].size() > 0 ? mq[i][0][FW-3-VW -: PW] : '0);
    check("request", request_o, req);
    for (int i = 0; i < VC; i++) if (req[i]) check("out_port", out_port_o[i], op[i]);
    check("overflow", overflow_o, m_ovf);
    check("proto_err", proto_err_o, m_perr);
    pv = -1; dv = -1;
    for (int i = 0; i < VC; i++) if (g[i] && req[i] && pv < 0) pv = i;
    if ($countones(g) > 1 || (g & ~req) != '0) m_perr = 1;
    if (pv < 0)
      for (int i = 0; i < VC; i++)
        if (mq[i].size() > 0 && !m_active[i] && !mq[i][0][FW-1] && dv < 0) dv = i;
    if (pv >= 0) begin
      fr = mq[pv].pop_front();
      sb_q.push_back('{1'b1, fr, op[pv], VW'(pv)});
      if (fr[FW-1]) begin
        m_active[pv] = !fr[FW-2];
        m_port[pv] = fr[FW-3-VW -: PW];
      end else if (fr[FW-2]) m_active[pv] = 0;
    end
    if (dv >= 0) begin
      fr = mq[dv].pop_front();
      sb_q.push_back('{1'b0, '0, '0, VW'(dv)});
      m_perr = 1;
    end
    if (v) begin
      wv = int'(f[FW-3 -: VW]);
      if (mq[wv].size() < BD) mq[wv].push_back(f);
      else m_ovf = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    flit_valid_i = 0; flit_i = '0; grant_i = '0;
    #2 rst_n = 1'b1; in_rst = 1'b1;
    #1;
    check("rst_request", request_o, 0);
    check("rst_flit_valid", flit_valid_o, 0);
    check("rst_flit", flit_o, 0);
    check("rst_credit", {credit_valid_o, credit_vc_o}, 0);
    check("rst_flags", {overflow_o, proto_err_o}, 0);
    for (int i = 0; i < VC; i++) begin
      mq[i].delete(); m_active[i] = 0; m_port[i] = '0; in_pkt[i] = 0;
    end
    m_ovf = 0; m_perr = 0;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; in_rst = 1'b0;
  endtask

  initial begin
    logic [VC-1:0] g, r;
    bit h, t;
    int vc, k;
    rst_n = 1'b0; flit_valid_i = 0; flit_i = '0; grant_i = '0;
    @(negedge clk);
    do_reset();

    // single-flit packet vc2 dest3
    step(1, mk(1, 1, 2, 3, 32'h11), '0);
    step(0, '0, 4'b0100);
    check("t1_flit_valid", flit_valid_o, 1);
    check("t1_port", flit_port_o, 3);
    check("t1_credit_vc", credit_vc_o, 2);
    step(0, '0, '0);
    check("t1_idle_req", request_o, 0);

    // 4-flit packet on vc1 dest4, grant every cycle
    step(1, mk(1, 0, 1, 4, 32'h20), '0);
    step(1, mk(0, 0, 1, 0, 32'h21), 4'b0010);
    step(1, mk(0, 0, 1, 0, 32'h22), 4'b0010);
    step(1, mk(0, 1, 1, 0, 32'h23), 4'b0010);
    step(0, '0, 4'b0010);
    check("t2_tail_port", flit_port_o, 4);
    step(0, '0, '0);
    check("t2_req_after_tail", request_o, 0);

    // overflow, then full-FIFO write with simultaneous pop
    do_reset();
    step(1, mk(1, 0, 0, 2, 32'h30), '0);
    for (int i = 1; i < 5; i++) step(1, mk(0, 0, 0, 0, 32'h30 + i), '0);
    check("t3_overflow", overflow_o, 1);
    step(1, mk(0, 1, 0, 0, 32'h3f), 4'b0001);
    for (int i = 0; i < 5; i++) step(0, '0, 4'b0001);

    // multi-bit grant and orphan body flit
    do_reset();
    step(1, mk(1, 1, 0, 1, 32'h40), '0);
    step(1, mk(1, 1, 1, 2, 32'h41), '0);
    step(0, '0, 4'b0011);
    check("t4_proto_err", proto_err_o, 1);
    check("t4_vc0_popped", credit_vc_o, 0);
    step(1, mk(0, 0, 3, 0, 32'h43), '0);
    step(0, '0, '0);
    check("t4_discard_vc", {credit_valid_o, flit_valid_o, credit_vc_o}, {2'b10, 2'd3});
    step(0, '0, 4'b0010);

    // reset mid-packet, then leftover tail is discarded
    do_reset();
    step(1, mk(1, 0, 1, 2, 32'h50), '0);
    step(1, mk(0, 0, 1, 0, 32'h51), 4'b0010);
    step(1, mk(0, 1, 1, 0, 32'h52), 4'b0010);
    do_reset();
    step(1, mk(0, 1, 1, 0, 32'h52), '0);
    step(0, '0, '0);
    check("t5_proto_err", proto_err_o, 1);
    check("t5_no_req", request_o, 0);

    // pointer wrap: 10 packets through vc0
    do_reset();
    for (int i = 0; i < 10; i++) step(1, mk(1, 1, 0, i % PN, 32'h600 + i), (i > 0) ? 4'b0001 : 4'b0000);
    step(0, '0, 4'b0001);
    step(0, '0, '0);

    // randomized traffic segments
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        vc = $urandom_range(0, VC - 1);
        if ($urandom_range(0, 19) == 0) begin
          h = 1'($urandom); t = 1'($urandom);
        end else if (!in_pkt[vc]) begin
          h = 1; t = ($urandom_range(0, 3) == 0);
        end else begin
          h = 0; t = ($urandom_range(0, 2) == 0);
        end
        r = model_req();
        k = $urandom_range(0, 9);
        g = '0;
        if (k < 6 && r != '0) begin
          do k = $urandom_range(0, VC - 1); while (!r[k]);
          g[k] = 1'b1;
        end else if (k >= 8) g = VC'($urandom);
        if ($urandom_range(0, 9) < ((seg == 0) ? 8 : 5)) begin
          in_pkt[vc] = !t;
          step(1, mk(h, t, vc, $urandom_range(0, PN - 1), $urandom), g);
        end else begin
          step(0, '0, g);
        end
      end
      for (int c = 0; c < 40; c++) begin
        r = model_req();
        g = '0;
        for (int i = 0; i < VC; i++) if (r[i] && g == '0) g[i] = 1'b1;
        step(0, '0, g);
      end
    end

    step(0, '0, '0);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_vc_buffer.md
INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

Interface
REQ-001 SHALL have parameter vc_Num, default 4, the number of virtual channels per input port.
REQ-002 SHALL have parameter port_Num, default 5, the number of router ports; PW = $clog2(port_Num).
REQ-003 SHALL have parameter buf_Depth, default 4, the flit slots per VC (power of two).
REQ-004 SHALL have parameter flit_W, default 32; VW = $clog2(vc_Num). Flit fields: bit flit_W-1 is head, bit flit_W-2 is tail, the next VW bits are vc, the next PW bits are dest port, and the rest is payload.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-high (asserted = 1).
REQ-007 SHALL have port flit_valid_i, input, 1 bit: flit_i is valid this cycle.
REQ-008 SHALL have port flit_i, input, flit_W bits: the incoming flit.
REQ-009 SHALL have port request_o, output, [vc_Num-1:0]: per-VC switch request to the allocator.
REQ-010 SHALL have port out_port_o, output, [vc_Num-1:0][PW-1:0]: per-VC requested output port.
REQ-011 SHALL have port grant_i, input, [vc_Num-1:0]: per-VC grant from the allocator.
REQ-012 SHALL have port flit_valid_o, output, 1 bit: flit_o is valid.
REQ-013 SHALL have port flit_o, output, flit_W bits: the forwarded flit.
REQ-014 SHALL have port flit_port_o, output, PW bits: the output port for flit_o.
REQ-015 SHALL have port credit_valid_o, output, 1 bit: a one-cycle credit return to upstream.
REQ-016 SHALL have port credit_vc_o, output, VW bits: the VC being credited.
REQ-017 SHALL have port overflow_o, output, 1 bit: sticky, set on a dropped write.
REQ-018 SHALL have port proto_err_o, output, 1 bit: sticky, set on a protocol violation.

Function
REQ-019 SHALL keep one circular FIFO per VC with buf_Depth entries, read/write pointers, and a count of width $clog2(buf_Depth)+1.
REQ-020 SHALL write flit_i into the FIFO selected by its vc field on a clock edge where flit_valid_i = 1.
REQ-021 SHALL drop a write to a full FIFO, leave that FIFO unchanged and set overflow_o, unless the same VC pops in the same cycle; in that case the write SHALL be accepted.
REQ-022 SHALL wrap the FIFO pointers modulo buf_Depth with no lost or duplicated flit.
REQ-023 SHALL give each VC a two-state machine: IDLE and ACTIVE.
REQ-024 SHALL, in IDLE with a non-empty FIFO and a head flit at the front, assert request_o[v] combinationally and drive out_port_o[v] from the front flit's dest field.
REQ-025 SHALL, in IDLE with a non-head flit at the front, pop and discard that flit, set proto_err_o, issue its credit, and not request.
REQ-026 SHALL, in ACTIVE, assert request_o[v] whenever the FIFO is non-empty and drive out_port_o[v] from the port register latched at the head grant.
REQ-027 SHALL, when grant_i[v] & request_o[v] = 1, pop the front flit of VC v.
REQ-028 SHALL, on a head-flit grant, latch the dest port and go to ACTIVE; if that flit is also tail, it SHALL stay IDLE.
REQ-029 SHALL, on a tail-flit grant in ACTIVE, return to IDLE.
REQ-030 SHALL honour only the lowest-index bit of grant_i that is also requesting.
REQ-031 SHALL set proto_err_o when grant_i has more than one bit set, or has a bit set for a non-requesting VC; no pop SHALL occur for the ignored bits.
REQ-032 SHALL register the popped flit on the next edge: flit_valid_o, flit_o and flit_port_o are valid for exactly one cycle, one cycle after the grant cycle.
REQ-033 SHALL assert credit_valid_o with credit_vc_o in the same cycle as flit_valid_o, and also for the discards in REQ-025; at most one credit SHALL be issued per cycle.
REQ-034 SHALL, for a write to an empty IDLE VC at cycle N, raise request_o in cycle N+1; with a grant in N+1, flit_valid_o SHALL be high in N+2.
REQ-035 SHALL deassert request_o combinationally once the last flit of a VC has been granted, in the following cycle.

Reset
REQ-036 SHALL, while rst_n = 1, asynchronously empty all FIFOs, set all VCs to IDLE, and clear latched ports, flit_valid_o, flit_o, flit_port_o, credit_valid_o, credit_vc_o, overflow_o and proto_err_o; request_o SHALL then be 0.
REQ-037 SHALL, on reset asserted mid-packet, discard all buffered flits; after release the VC is IDLE and the first non-head flit triggers REQ-025.

Verification
REQ-038 Single-flit packet (head = tail = 1, vc 2, dest 3) written at cycle 0, grant_i = 4'b0100 at cycle 1 -> request_o[2] = 1 with out_port_o[2] = 3 in cycle 1; flit_valid_o = 1, flit_port_o = 3, credit_vc_o = 2 in cycle 2; VC2 IDLE.
REQ-039 4-flit packet on vc 1, dest 4, grants every cycle -> four flits out in consecutive cycles, all with flit_port_o = 4; request_o[1] = 0 after the tail; four credits on vc 1.
REQ-040 Five writes to vc 0 with no grant (buf_Depth = 4) -> 5th write dropped, overflow_o = 1; then a full-FIFO write with a simultaneous grant on vc 0 -> write accepted, count stays 4.
REQ-041 grant_i = 4'b0011 with VC0 and VC1 both requesting -> only VC0 pops and proto_err_o = 1; body flit on IDLE vc 3 -> discarded, credit_vc_o = 3, no request.
REQ-042 Reset asserted after 2 of 3 flits on vc 1 forwarded -> all outputs 0 immediately; after release, writing the leftover tail -> discard plus proto_err_o = 1.
REQ-043 Push/pop wrap: 10 packets through vc 0 -> output order equals input order, pointers wrap correctly.
